// File: rtl/instr_datapath.sv
// instr_datapath: two-stage check/route datapath.
// Each instruction adds data0+data1 and looks up a loadable check table at
// {data0,data1}. It flags ok (sum matches the table) and ovf (carry out). It
// then routes the selected value (sum, table value or data0>data1 compare)
// into one of NCH channel registers, optionally accumulating into that channel.
// Optional feature macro: INSTR_DATAPATH_OVF_CNT_EN enables a saturating
// overflow event counter on ovf_cnt. When it is undefined, ovf_cnt is tied to 0.
module instr_datapath #(
   parameter int WIDTH = 2,
   parameter int NCH   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       data0,
   input  logic [WIDTH-1:0]       data1,
   input  logic [7:0]             instruction,
   input  logic                   tbl_we,
   input  logic [2*WIDTH-1:0]     tbl_addr,
   input  logic [WIDTH-1:0]       tbl_wdata,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   ok,
   output logic                   ovf,
   output logic [7:0]             instr_out,
   output logic [WIDTH-1:0]       result,
   output logic [NCH*WIDTH-1:0]   ch_out,
   output logic [7:0]             ovf_cnt
);

   localparam int CH_BITS = $clog2(NCH);
   localparam int DEPTH   = 1 << (2 * WIDTH);

   // Instruction byte layout. The rsvd bit is carried through to instr_out
   // but otherwise ignored.
   typedef struct packed {
      logic       spc;
      logic       acc;
      logic       mem;
      logic       rsvd;
      logic [3:0] ch;
   } instr_t;

   // Stage 1 holding registers
   logic               s1_valid;
   logic [WIDTH-1:0]   s1_d0;
   logic [WIDTH-1:0]   s1_d1;
   instr_t             s1_instr;

   logic               s2_load;
   logic               accept;

   logic [WIDTH-1:0]   tbl [DEPTH];
   logic [WIDTH-1:0]   ch  [NCH];

   // Stage 2 combinational results
   logic [CH_BITS-1:0] ch_idx;
   logic [WIDTH:0]     sum_full;
   logic [WIDTH:0]     acc_full;
   logic [WIDTH-1:0]   tv;
   logic [WIDTH-1:0]   spc_val;
   logic [WIDTH-1:0]   sel;
   logic [WIDTH-1:0]   nxt_result;
   logic               nxt_ovf;
   logic               nxt_ok;

   // Handshake. S1 may refill in the same cycle that it hands over to S2.
   assign s2_load  = s1_valid & (~out_valid | out_ready);
   assign in_ready = ~s1_valid | s2_load;
   assign accept   = in_valid & in_ready;

   // Stage 1: capture the operands and instruction on accept, empty on hand-over
   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_d0    <= '0;
         s1_d1    <= '0;
         s1_instr <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_d0    <= data0;
         s1_d1    <= data1;
         s1_instr <= instr_t'(instruction);
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // Check table: write port independent of the pipeline. Read-first behaviour
   // comes from the asynchronous read of the pre-edge contents.
   // NOTE: this memory is reset because the table must read as zero after reset; that forces flops, not RAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      end else if (tbl_we) begin
         tbl[tbl_addr] <= tbl_wdata;
      end
   end

   // Stage 2 datapath: compute add, lookup, select and optional accumulate
   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      ch_idx     = s1_instr.ch[CH_BITS-1:0];
      sum_full   = {1'b0, s1_d0} + {1'b0, s1_d1};
      tv         = tbl[{s1_d0, s1_d1}];
      spc_val    = WIDTH'(s1_d0 > s1_d1);
      nxt_ok     = (sum_full[WIDTH-1:0] == tv);
      sel        = sum_full[WIDTH-1:0];
      if (s1_instr.spc)      sel = spc_val;
      else if (s1_instr.mem) sel = tv;
      // The channel register is read directly. It already holds the
      // preceding instruction's write, so back-to-back accumulates are never stale.
      acc_full   = {1'b0, ch[ch_idx]} + {1'b0, sel};
      nxt_result = sel;
      nxt_ovf    = sum_full[WIDTH];
      if (s1_instr.acc) begin
         nxt_result = acc_full[WIDTH-1:0];
         nxt_ovf    = acc_full[WIDTH];
      end
   end

   // Stage 2 output registers and channel write-back. Outputs hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         ok        <= 1'b0;
         ovf       <= 1'b0;
         instr_out <= '0;
         result    <= '0;
         for (int k = 0; k < NCH; k++) ch[k] <= '0;
      end else if (s2_load) begin
         out_valid  <= 1'b1;
         ok         <= nxt_ok;
         ovf        <= nxt_ovf;
         instr_out  <= s1_instr;
         result     <= nxt_result;
         ch[ch_idx] <= nxt_result;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

   // Flatten the channel registers onto the output bus
   always_comb begin
      ch_out = '0;
      for (int k = 0; k < NCH; k++) ch_out[k*WIDTH +: WIDTH] = ch[k];
   end

`ifdef INSTR_DATAPATH_OVF_CNT_EN
   // Overflow event counter: one count per loaded instruction with ovf, saturating at 255
   always_ff @(posedge clk) begin
      if (rst)
         ovf_cnt <= '0;
      else if (s2_load && nxt_ovf && (ovf_cnt != 8'hFF))
         ovf_cnt <= ovf_cnt + 8'd1;
   end
`else
   assign ovf_cnt = '0;
`endif

endmodule
